// File: rtl/barrel_shifter_stage.sv
// barrel_shifter_stage: multi-cycle operand-2 shifter.
// A start in IDLE captures the operand and control fields. Register-specified
// shifts spend one cycle in READ_RS to fetch Rs[7:0]. SHIFT then registers the
// result and carry and pulses valid for one cycle.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   start              begin operation (sampled only in IDLE)
//   rmValue            operand to shift (Rm)
//   rsValue            shift-amount register (Rs), bits [7:0] used
//   shiftType          00 LSL, 01 LSR, 10 ASR, 11 ROR
//   immShiftAmount     immediate shift amount
//   shiftByRegister    amount taken from rsValue[7:0]
//   immediateOperand   operand = imm8 rotated right by 2*rotate
//   imm8, rotate       immediate value and rotate field
//   carryFlag          current C flag
//   busy               high in every state except IDLE
//   valid              one-cycle pulse when the result updates
//   barrelOutput       registered result
//   shifterCarryOut    registered shifter carry
module barrel_shifter_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] rmValue,
    input  logic [31:0] rsValue,
    input  logic [1:0]  shiftType,
    input  logic [4:0]  immShiftAmount,
    input  logic        shiftByRegister,
    input  logic        immediateOperand,
    input  logic [7:0]  imm8,
    input  logic [3:0]  rotate,
    input  logic        carryFlag,
    output logic        busy,
    output logic        valid,
    output logic [31:0] barrelOutput,
    output logic        shifterCarryOut
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AMT_W  = 5;
    localparam int unsigned RS_W   = 8;
    localparam int unsigned IMM_W  = 8;
    localparam int unsigned ROT_W  = 4;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ_RS = 2'd1,
        SHIFT   = 2'd2
    } state_e;

    // Operand and control fields captured on an accepted start.
    typedef struct packed {
        logic [DATA_W-1:0] rm;
        logic [1:0]        shift_type;
        logic [AMT_W-1:0]  imm_amt;
        logic              by_reg;
        logic              imm_op;
        logic [IMM_W-1:0]  imm8;
        logic [ROT_W-1:0]  rotate;
        logic              carry_in;
    } op_t;

    state_e            state_q, state_d;
    op_t               op_q, op_d;
    logic [RS_W-1:0]   rs_q, rs_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              carry_q, carry_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] shift_res_c;
    logic              shift_carry_c;

    // Only the low byte of Rs is meaningful.
    logic unused_rs_hi;
    assign unused_rs_hi = ^rsValue[31:8];

    // Standard shift by n = 1..31; returns {carry, result}.
    function automatic logic [DATA_W:0] shift_std(
        input logic [1:0]        t,
        input logic [DATA_W-1:0] v,
        input logic [AMT_W-1:0]  n
    );
        logic [DATA_W-1:0] r;
        logic              c;
        case (t)
            SH_LSL: begin
                r = v << n;
                c = v[5'(6'd32 - {1'b0, n})];
            end
            SH_LSR: begin
                r = v >> n;
                c = v[n - 5'd1];
            end
            SH_ASR: begin
                r = 32'($signed(v) >>> n);
                c = v[n - 5'd1];
            end
            default: begin
                r = (v >> n) | (v << (6'd32 - {1'b0, n}));
                c = v[n - 5'd1];
            end
        endcase
        return {c, r};
    endfunction

    // Shift datapath, evaluated from the captured operation.
    always_comb begin
        logic [DATA_W-1:0] imm32;
        logic [AMT_W-1:0]  rot_amt;
        logic [RS_W-1:0]   s;
        logic [AMT_W-1:0]  n;

        shift_res_c   = op_q.rm;
        shift_carry_c = op_q.carry_in;
        imm32         = 32'(op_q.imm8);
        rot_amt       = {op_q.rotate, 1'b0};
        s             = rs_q;
        n             = op_q.imm_amt;

        if (op_q.imm_op) begin
            // Rotated immediate; carry is C when no rotation, else result[31].
            if (rot_amt == 5'd0) begin
                shift_res_c   = imm32;
                shift_carry_c = op_q.carry_in;
            end else begin
                {shift_carry_c, shift_res_c} = shift_std(SH_ROR, imm32, rot_amt);
            end
        end else if (op_q.by_reg) begin
            if (s == 8'd0) begin
                shift_res_c   = op_q.rm;
                shift_carry_c = op_q.carry_in;
            end else if (s < 8'd32) begin
                {shift_carry_c, shift_res_c} = shift_std(op_q.shift_type, op_q.rm, s[4:0]);
            end else begin
                case (op_q.shift_type)
                    SH_LSL: begin
                        shift_res_c   = '0;
                        shift_carry_c = (s == 8'd32) ? op_q.rm[0] : 1'b0;
                    end
                    SH_LSR: begin
                        shift_res_c   = '0;
                        shift_carry_c = (s == 8'd32) ? op_q.rm[31] : 1'b0;
                    end
                    SH_ASR: begin
                        shift_res_c   = {DATA_W{op_q.rm[31]}};
                        shift_carry_c = op_q.rm[31];
                    end
                    default: begin
                        // ROR by a multiple of 32 leaves Rm, carry = Rm[31].
                        if (s[4:0] == 5'd0) begin
                            shift_res_c   = op_q.rm;
                            shift_carry_c = op_q.rm[31];
                        end else begin
                            {shift_carry_c, shift_res_c} = shift_std(SH_ROR, op_q.rm, s[4:0]);
                        end
                    end
                endcase
            end
        end else begin
            if (n != 5'd0) begin
                {shift_carry_c, shift_res_c} = shift_std(op_q.shift_type, op_q.rm, n);
            end else begin
                // Amount 0 encodes LSL#0, LSR#32, ASR#32 and RRX.
                case (op_q.shift_type)
                    SH_LSL: begin
                        shift_res_c   = op_q.rm;
                        shift_carry_c = op_q.carry_in;
                    end
                    SH_LSR: begin
                        shift_res_c   = '0;
                        shift_carry_c = op_q.rm[31];
                    end
                    SH_ASR: begin
                        shift_res_c   = {DATA_W{op_q.rm[31]}};
                        shift_carry_c = op_q.rm[31];
                    end
                    default: begin
                        shift_res_c   = {op_q.carry_in, op_q.rm[31:1]};
                        shift_carry_c = op_q.rm[0];
                    end
                endcase
            end
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rs_d     = rs_q;
        result_d = result_q;
        carry_d  = carry_q;
        valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d.rm         = rmValue;
                    op_d.shift_type = shiftType;
                    op_d.imm_amt    = immShiftAmount;
                    op_d.by_reg     = shiftByRegister;
                    op_d.imm_op     = immediateOperand;
                    op_d.imm8       = imm8;
                    op_d.rotate     = rotate;
                    op_d.carry_in   = carryFlag;
                    // Immediate operand overrides register-specified shift.
                    state_d = (shiftByRegister && !immediateOperand) ? READ_RS : SHIFT;
                end
            end
            READ_RS: begin
                rs_d    = rsValue[7:0];
                state_d = SHIFT;
            end
            SHIFT: begin
                result_d = shift_res_c;
                carry_d  = shift_carry_c;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rs_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rs_q     <= rs_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            valid_q  <= valid_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign valid           = valid_q;
    assign barrelOutput    = result_q;
    assign shifterCarryOut = carry_q;

endmodule

// File: tb/tb_barrel_shifter_stage.sv
// Directed bench for barrel_shifter_stage with hand-computed expectations.
module tb_barrel_shifter_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] rmValue;
    logic [31:0] rsValue;
    logic [1:0]  shiftType;
    logic [4:0]  immShiftAmount;
    logic        shiftByRegister;
    logic        immediateOperand;
    logic [7:0]  imm8;
    logic [3:0]  rotate;
    logic        carryFlag;
    logic        busy;
    logic        valid;
    logic [31:0] barrelOutput;
    logic        shifterCarryOut;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    barrel_shifter_stage dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .rmValue          (rmValue),
        .rsValue          (rsValue),
        .shiftType        (shiftType),
        .immShiftAmount   (immShiftAmount),
        .shiftByRegister  (shiftByRegister),
        .immediateOperand (immediateOperand),
        .imm8             (imm8),
        .rotate           (rotate),
        .carryFlag        (carryFlag),
        .busy             (busy),
        .valid            (valid),
        .barrelOutput     (barrelOutput),
        .shifterCarryOut  (shifterCarryOut)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic [1:0] t, input logic [4:0] amt, input logic byreg,
                         input logic immop, input logic [31:0] rm, input logic [7:0] i8,
                         input logic [3:0] rot, input logic cf, input logic [31:0] rs);
        shiftType        = t;
        immShiftAmount   = amt;
        shiftByRegister  = byreg;
        immediateOperand = immop;
        rmValue          = rm;
        imm8             = i8;
        rotate           = rot;
        carryFlag        = cf;
        rsValue          = rs;
    endtask

    // Called with start already raised ahead of the accepting edge.
    task automatic complete(input string tag, input logic [31:0] rs_late, input int exp_lat,
                            input logic [31:0] exp_res, input logic exp_c);
        int lat;
        bit got;
        @(posedge clk);
        #1;
        start   = 1'b0;
        rsValue = rs_late;
        check({tag, " busy"}, 32'(busy), 32'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid === 1'b1) got = 1'b1;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, barrelOutput, exp_res);
        check({tag, " carry"}, 32'(shifterCarryOut), 32'(exp_c));
        @(posedge clk);
        #1;
        check({tag, " single pulse"}, 32'(valid), 32'd0);
        check({tag, " hold"}, barrelOutput, exp_res);
    endtask

    task automatic run_op(input string tag, input logic [31:0] rs_late, input int exp_lat,
                          input logic [31:0] exp_res, input logic exp_c);
        @(negedge clk);
        start = 1'b1;
        complete(tag, rs_late, exp_lat, exp_res, exp_c);
    endtask

    initial begin
        int pulses;
        int doubles;
        logic prev;

        reset = 1'b1;
        start = 1'b0;
        setup(2'b00, 5'd0, 1'b0, 1'b0, 32'h0, 8'h0, 4'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset valid", 32'(valid), 32'd0);
        check("reset result", barrelOutput, 32'h0);
        check("reset carry", 32'(shifterCarryOut), 32'd0);

        // First start accepted on the first edge after reset release.
        setup(2'b00, 5'd4, 1'b0, 1'b0, 32'h8000_000F, 8'h0, 4'h0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        complete("lsl4", 32'h0, 1, 32'h0000_00F0, 1'b0);

        setup(2'b11, 5'd0, 1'b0, 1'b0, 32'h0000_0003, 8'h0, 4'h0, 1'b1, 32'h0);
        run_op("rrx", 32'h0, 1, 32'h8000_0001, 1'b1);
        setup(2'b10, 5'd0, 1'b0, 1'b0, 32'h8000_0000, 8'h0, 4'h0, 1'b0, 32'h0);
        run_op("asr0", 32'h0, 1, 32'hFFFF_FFFF, 1'b1);
        setup(2'b01, 5'd0, 1'b0, 1'b0, 32'h8000_0001, 8'h0, 4'h0, 1'b0, 32'h0);
        run_op("lsr0", 32'h0, 1, 32'h0000_0000, 1'b1);
        setup(2'b00, 5'd0, 1'b0, 1'b0, 32'h1234_5678, 8'h0, 4'h0, 1'b1, 32'h0);
        run_op("lsl0", 32'h0, 1, 32'h1234_5678, 1'b1);
        setup(2'b10, 5'd4, 1'b0, 1'b0, 32'hF000_0018, 8'h0, 4'h0, 1'b0, 32'h0);
        run_op("asr4", 32'h0, 1, 32'hFF00_0001, 1'b1);
        setup(2'b11, 5'd8, 1'b0, 1'b0, 32'h1234_5678, 8'h0, 4'h0, 1'b1, 32'h0);
        run_op("ror8", 32'h0, 1, 32'h7812_3456, 1'b0);
        setup(2'b10, 5'd31, 1'b0, 1'b0, 32'h7FFF_FFFF, 8'h0, 4'h0, 1'b0, 32'h0);
        run_op("asr31", 32'h0, 1, 32'h0000_0000, 1'b1);
        setup(2'b00, 5'd31, 1'b0, 1'b0, 32'h0000_0003, 8'h0, 4'h0, 1'b0, 32'h0);
        run_op("lsl31", 32'h0, 1, 32'h8000_0000, 1'b1);

        setup(2'b01, 5'd0, 1'b1, 1'b0, 32'h8000_0000, 8'h0, 4'h0, 1'b0, 32'h120);
        run_op("reg lsr32", 32'h120, 2, 32'h0, 1'b1);
        setup(2'b01, 5'd0, 1'b1, 1'b0, 32'h8000_0000, 8'h0, 4'h0, 1'b0, 32'h121);
        run_op("reg lsr33", 32'h121, 2, 32'h0, 1'b0);

        setup(2'b00, 5'd0, 1'b1, 1'b1, 32'h0, 8'hFF, 4'h4, 1'b0, 32'h0);
        run_op("imm rot4", 32'h0, 1, 32'hFF00_0000, 1'b1);
        setup(2'b00, 5'd0, 1'b0, 1'b1, 32'h0, 8'hFF, 4'h0, 1'b0, 32'h0);
        run_op("imm rot0", 32'h0, 1, 32'h0000_00FF, 1'b0);

        // Rs is sampled in READ_RS, not at start: the late value must win.
        setup(2'b11, 5'd0, 1'b1, 1'b0, 32'hABCD_0000, 8'h0, 4'h0, 1'b1, 32'h55);
        run_op("reg ror0", 32'h100, 2, 32'hABCD_0000, 1'b1);
        setup(2'b00, 5'd0, 1'b1, 1'b0, 32'h0000_0001, 8'h0, 4'h0, 1'b0, 32'h20);
        run_op("reg lsl32", 32'h20, 2, 32'h0, 1'b1);
        setup(2'b00, 5'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 8'h0, 4'h0, 1'b1, 32'h28);
        run_op("reg lsl40", 32'h28, 2, 32'h0, 1'b0);
        setup(2'b10, 5'd0, 1'b1, 1'b0, 32'h8000_0000, 8'h0, 4'h0, 1'b0, 32'hC8);
        run_op("reg asr200", 32'hC8, 2, 32'hFFFF_FFFF, 1'b1);
        setup(2'b11, 5'd0, 1'b1, 1'b0, 32'h0000_0001, 8'h0, 4'h0, 1'b1, 32'h40);
        run_op("reg ror64", 32'h40, 2, 32'h0000_0001, 1'b0);
        setup(2'b11, 5'd0, 1'b1, 1'b0, 32'h0000_000F, 8'h0, 4'h0, 1'b0, 32'h24);
        run_op("reg ror36", 32'h24, 2, 32'hF000_0000, 1'b1);
        setup(2'b01, 5'd0, 1'b1, 1'b0, 32'h0000_00F8, 8'h0, 4'h0, 1'b0, 32'h0);
        run_op("reg lsr4", 32'h4, 2, 32'h0000_000F, 1'b1);
        setup(2'b00, 5'd0, 1'b1, 1'b0, 32'h8000_0001, 8'h0, 4'h0, 1'b0, 32'h0);
        run_op("reg lsl1", 32'h1, 2, 32'h0000_0002, 1'b1);

        // Start held high: immediate shift gives one valid every 2 cycles.
        setup(2'b00, 5'd1, 1'b0, 1'b0, 32'h0000_0001, 8'h0, 4'h0, 1'b0, 32'h0);
        @(negedge clk);
        start   = 1'b1;
        pulses  = 0;
        doubles = 0;
        prev    = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) pulses++;
            if (valid === 1'b1 && prev === 1'b1) doubles++;
            prev = valid;
        end
        start = 1'b0;
        check("held imm pulses", 32'(pulses), 32'd6);
        check("held imm back-to-back", 32'(doubles), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("held imm drained", 32'(busy), 32'd0);

        // Start held high: register shift gives one valid every 3 cycles.
        setup(2'b01, 5'd0, 1'b1, 1'b0, 32'h0000_0004, 8'h0, 4'h0, 1'b1, 32'h1);
        @(negedge clk);
        start   = 1'b1;
        pulses  = 0;
        doubles = 0;
        prev    = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) pulses++;
            if (valid === 1'b1 && prev === 1'b1) doubles++;
            prev = valid;
        end
        start = 1'b0;
        check("held reg pulses", 32'(pulses), 32'd4);
        check("held reg back-to-back", 32'(doubles), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("held reg drained", 32'(busy), 32'd0);
        check("held reg result", barrelOutput, 32'h0000_0002);

        // Reset during READ_RS clears outputs at once and suppresses valid.
        setup(2'b00, 5'd0, 1'b1, 1'b0, 32'h0000_0001, 8'h0, 4'h0, 1'b0, 32'h2);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("abort busy before", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("abort result", barrelOutput, 32'h0);
        check("abort carry", 32'(shifterCarryOut), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort valid", 32'(valid), 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) pulses++;
        end
        check("abort no valid", 32'(pulses), 32'd0);

        setup(2'b01, 5'd2, 1'b0, 1'b0, 32'h0000_000E, 8'h0, 4'h0, 1'b0, 32'h0);
        run_op("post reset lsr2", 32'h0, 1, 32'h0000_0003, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
